// File: rtl/fd_pkg.sv
// Shared constants for the face-detect window scanner: image geometry, FSM encodings
// and the classifier corner index numbering.
package fd_pkg;

  localparam int II_WIDTH    = 160;
  localparam int II_HEIGHT   = 120;
  localparam int ADDR_W      = 15;
  localparam int DEF_WIN_W   = 24;
  localparam int DEF_WIN_H   = 8;
  localparam int DEF_STEP    = 4;
  localparam int TIMEOUT     = 63;

  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int CNT_W = 10;

  // corner numbering as seen by the classifier
  localparam int C0 = 0;
  localparam int C1 = 1;
  localparam int C2 = 2;
  localparam int C3 = 3;
  localparam int C4 = 4;
  localparam int C5 = 5;
  localparam int C6 = 6;
  localparam int C7 = 7;

  typedef enum logic [5:0] {
    S_IDLE    = 6'b000001,
    S_LOAD    = 6'b000010,
    S_ISSUE   = 6'b000100,
    S_WAIT    = 6'b001000,
    S_ADVANCE = 6'b010000,
    S_DONE    = 6'b100000
  } scan_state_t;

  // last stride-aligned position whose window still fits inside extent-1
  function automatic int last_pos(input int extent, input int win, input int step);
    return ((extent - 1 - win) / step) * step;
  endfunction

endpackage

// File: rtl/window_scan_ctrl_if.sv
// Scanner <-> classifier handshake: eight corner addresses, detect strobe and result.
interface window_scan_ctrl_if;
  import fd_pkg::*;

  logic [ADDR_W-1:0] address_0;
  logic [ADDR_W-1:0] address_1;
  logic [ADDR_W-1:0] address_2;
  logic [ADDR_W-1:0] address_3;
  logic [ADDR_W-1:0] address_4;
  logic [ADDR_W-1:0] address_5;
  logic [ADDR_W-1:0] address_6;
  logic [ADDR_W-1:0] address_7;
  logic              detect_en;
  logic              detect_done;
  logic              detected_flag;

  modport master (
    output address_0, address_1, address_2, address_3,
           address_4, address_5, address_6, address_7, detect_en,
    input  detect_done, detected_flag
  );

  modport slave (
    input  address_0, address_1, address_2, address_3,
           address_4, address_5, address_6, address_7, detect_en,
    output detect_done, detected_flag
  );

endinterface

// File: rtl/window_addr_gen.sv
// Corner address generator: adds fixed band/height offsets to row_base + x and
// registers all eight corners on load. No multipliers; offsets are elaboration constants.
module window_addr_gen
  import fd_pkg::*;
#(
  parameter int WIN_W = DEF_WIN_W,
  parameter int WIN_H = DEF_WIN_H
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [ADDR_W-1:0]       row_base,
  input  logic [X_W-1:0]          x,
  output logic [7:0][ADDR_W-1:0]  corner
);

  localparam int BAND = WIN_W / 3;
  localparam logic [ADDR_W-1:0] OFF_1T = ADDR_W'(BAND);
  localparam logic [ADDR_W-1:0] OFF_2T = ADDR_W'(2 * BAND);
  localparam logic [ADDR_W-1:0] OFF_3T = ADDR_W'(3 * BAND);
  localparam logic [ADDR_W-1:0] OFF_Y  = ADDR_W'(WIN_H * II_WIDTH);

  logic [ADDR_W-1:0] top_left;
  logic [ADDR_W-1:0] bot_left;

  assign top_left = row_base + ADDR_W'(x);
  assign bot_left = top_left + OFF_Y;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      corner <= '0;
    end else if (load) begin
      corner[C3] <= top_left;
      corner[C1] <= top_left + OFF_1T;
      corner[C5] <= top_left + OFF_2T;
      corner[C7] <= top_left + OFF_3T;
      corner[C2] <= bot_left;
      corner[C0] <= bot_left + OFF_1T;
      corner[C4] <= bot_left + OFF_2T;
      corner[C6] <= bot_left + OFF_3T;
    end
  end

endmodule

// File: rtl/window_scan_ctrl.sv
// Raster-order window scheduler for the three-band Haar classifier.
// Optional WAIT watchdog enabled by defining SCAN_TIMEOUT_EN.
//
//  state   | meaning
//  IDLE    | waiting for start; hit_count held
//  LOAD    | register corner addresses for (x,y)
//  ISSUE   | one-cycle detect_en pulse
//  WAIT    | wait for detect_done (or watchdog expiry)
//  ADVANCE | step x, wrap to next row, or finish
//  DONE    | one-cycle scan_done pulse
module window_scan_ctrl
  import fd_pkg::*;
#(
  parameter int WIN_W = DEF_WIN_W,
  parameter int WIN_H = DEF_WIN_H,
  parameter int STEP  = DEF_STEP
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  window_scan_ctrl_if.master   cls,
  output logic                 busy,
  output logic                 hit_valid,
  output logic [X_W-1:0]       hit_x,
  output logic [Y_W-1:0]       hit_y,
  output logic [CNT_W-1:0]     hit_count,
  output logic                 scan_done,
  output logic                 timeout_err
);

  localparam logic [X_W-1:0]    X_LAST   = X_W'(last_pos(II_WIDTH, WIN_W, STEP));
  localparam logic [Y_W-1:0]    Y_LAST   = Y_W'(last_pos(II_HEIGHT, WIN_H, STEP));
  localparam logic [X_W-1:0]    X_STEP   = X_W'(STEP);
  localparam logic [Y_W-1:0]    Y_STEP   = Y_W'(STEP);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(STEP * II_WIDTH);

  scan_state_t state, state_nxt;

  logic [X_W-1:0]          x;
  logic [Y_W-1:0]          y;
  logic [ADDR_W-1:0]       row_base;
  logic [7:0][ADDR_W-1:0]  corner;
  logic                    hit_valid_q;
  logic                    last_win;
  logic                    row_end;
  logic                    scan_go;
  logic                    tmo;

  assign row_end  = (x == X_LAST);
  assign last_win = row_end && (y == Y_LAST);
  assign scan_go  = (state == S_IDLE) && start && !abort;

  window_addr_gen #(.WIN_W(WIN_W), .WIN_H(WIN_H)) u_addr (
    .clk      (clk),
    .rst      (rst),
    .load     (state == S_LOAD),
    .row_base (row_base),
    .x        (x),
    .corner   (corner)
  );

  assign cls.address_0 = corner[C0];
  assign cls.address_1 = corner[C1];
  assign cls.address_2 = corner[C2];
  assign cls.address_3 = corner[C3];
  assign cls.address_4 = corner[C4];
  assign cls.address_5 = corner[C5];
  assign cls.address_6 = corner[C6];
  assign cls.address_7 = corner[C7];

`ifdef SCAN_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;

  // down-counter armed in ISSUE so it expires on the TIMEOUT-th WAIT cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
    end else if (state == S_ISSUE) begin
      wd_cnt <= WD_W'(TIMEOUT - 1);
    end else if (state == S_WAIT && wd_cnt != '0) begin
      wd_cnt <= wd_cnt - 1'b1;
    end
  end

  assign tmo = (state == S_WAIT) && !cls.detect_done && (wd_cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeout_err <= 1'b0;
    end else if (scan_go) begin
      timeout_err <= 1'b0;
    end else if (tmo && !abort) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign tmo         = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (start) state_nxt = S_LOAD;
        S_LOAD:    state_nxt = S_ISSUE;
        S_ISSUE:   state_nxt = S_WAIT;
        S_WAIT:    if (cls.detect_done || tmo) state_nxt = S_ADVANCE;
        S_ADVANCE: state_nxt = last_win ? S_DONE : S_LOAD;
        S_DONE:    state_nxt = S_IDLE;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cls.detect_en = 1'b0;
    scan_done     = 1'b0;
    busy          = 1'b0;
    hit_valid     = 1'b0;
    if (state != S_IDLE) busy = 1'b1;
    if (!abort) begin
      cls.detect_en = (state == S_ISSUE);
      scan_done     = (state == S_DONE);
      hit_valid     = hit_valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x           <= '0;
      y           <= '0;
      row_base    <= '0;
      hit_count   <= '0;
      hit_valid_q <= 1'b0;
      hit_x       <= '0;
      hit_y       <= '0;
    end else begin
      hit_valid_q <= 1'b0;
      if (scan_go) begin
        x         <= '0;
        y         <= '0;
        row_base  <= '0;
        hit_count <= '0;
      end
      if (state == S_WAIT && cls.detect_done && cls.detected_flag && !abort) begin
        hit_valid_q <= 1'b1;
        hit_x       <= x;
        hit_y       <= y;
        if (hit_count != {CNT_W{1'b1}}) hit_count <= hit_count + 1'b1;
      end
      if (state == S_ADVANCE && !abort && !last_win) begin
        if (row_end) begin
          x        <= '0;
          y        <= y + Y_STEP;
          row_base <= row_base + ROW_STEP;
        end else begin
          x <= x + X_STEP;
        end
      end
    end
  end

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Directed bench for window_scan_ctrl with a 3-cycle classifier model.
// Watchdog checks follow SCAN_TIMEOUT_EN.
module tb_window_scan_ctrl;
  import fd_pkg::*;

  logic clk = 1'b0;
  logic rst, start, abort;
  logic busy, hit_valid, scan_done, timeout_err;
  logic [7:0] hit_x;
  logic [6:0] hit_y;
  logic [9:0] hit_count;

  always #5 clk = ~clk;

  window_scan_ctrl_if ifc();

  window_scan_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .cls         (ifc),
    .busy        (busy),
    .hit_valid   (hit_valid),
    .hit_x       (hit_x),
    .hit_y       (hit_y),
    .hit_count   (hit_count),
    .scan_done   (scan_done),
    .timeout_err (timeout_err)
  );

  int   mode = 0;
  bit   model_on = 1'b1;
  logic m_done = 1'b0, m_flag = 1'b0, inj_done = 1'b0, inj_flag = 1'b0;
  int   pend = 0;
  int   cur_x = 0, cur_y = 0;
  int   en_cnt = 0, hv_cnt = 0, sd_cnt = 0;
  int   last_hx = 0, last_hy = 0, last_a3 = 0, last_a6 = 0;
  int   errors = 0, checks = 0;

  assign ifc.detect_done   = m_done | inj_done;
  assign ifc.detected_flag = m_flag | inj_flag;

  // classifier model: done 3 cycles after detect_en; hit decided from the top-left address
  always @(negedge clk) begin
    m_done = 1'b0;
    m_flag = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        m_done = 1'b1;
        m_flag = (mode == 2) || (mode == 1 && cur_x == 40 && cur_y == 20);
      end
    end
    if (ifc.detect_en) begin
      en_cnt++;
      last_a3 = int'(ifc.address_3);
      last_a6 = int'(ifc.address_6);
      if (model_on) begin
        pend  = 3;
        cur_x = int'(ifc.address_3) % II_WIDTH;
        cur_y = int'(ifc.address_3) / II_WIDTH;
      end
    end
    if (hit_valid) begin
      hv_cnt++;
      last_hx = int'(hit_x);
      last_hy = int'(hit_y);
    end
    if (scan_done) sd_cnt++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
  endtask

  task automatic wait_en(input int target, input int budget, input string tag);
    int n = 0;
    while (en_cnt < target && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, int'(en_cnt >= target), 1);
  endtask

  task automatic wait_sd(input int target, input int budget, input string tag);
    int n = 0;
    while (sd_cnt < target && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, int'(sd_cnt >= target), 1);
  endtask

  int e0, h0, s0;

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    tick(3);
    chk("rst_busy", int'(busy), 0);
    chk("rst_detect_en", int'(ifc.detect_en), 0);
    chk("rst_hit_count", int'(hit_count), 0);
    chk("rst_addr3", int'(ifc.address_3), 0);
    chk("rst_addr6", int'(ifc.address_6), 0);
    chk("rst_scan_done", int'(scan_done), 0);
    chk("rst_timeout_err", int'(timeout_err), 0);
    rst = 1'b1;
    tick(2);

    // 1: no hits, full frame
    mode = 0; e0 = en_cnt; h0 = hv_cnt; s0 = sd_cnt;
    pulse_start();
    wait_en(e0 + 1, 10, "t1_first_en");
    chk("t1_a3", int'(ifc.address_3), 0);
    chk("t1_a1", int'(ifc.address_1), 8);
    chk("t1_a5", int'(ifc.address_5), 16);
    chk("t1_a7", int'(ifc.address_7), 24);
    chk("t1_a2", int'(ifc.address_2), 1280);
    chk("t1_a0", int'(ifc.address_0), 1288);
    chk("t1_a4", int'(ifc.address_4), 1296);
    chk("t1_a6", int'(ifc.address_6), 1304);
    chk("t1_busy", int'(busy), 1);
    wait_sd(s0 + 1, 10000, "t1_scan_done_seen");
    chk("t1_windows", en_cnt - e0, 952);
    chk("t1_hit_count", int'(hit_count), 0);
    chk("t1_hits", hv_cnt - h0, 0);
    chk("t1_last_a3", last_a3, 17412);
    chk("t1_last_a6", last_a6, 18716);
    tick(1);
    chk("t1_busy_after", int'(busy), 0);
    chk("t1_scan_done_once", sd_cnt - s0, 1);

    // 2: single hit at (40,20)
    mode = 1; e0 = en_cnt; h0 = hv_cnt; s0 = sd_cnt;
    pulse_start();
    wait_sd(s0 + 1, 10000, "t2_scan_done_seen");
    chk("t2_hits", hv_cnt - h0, 1);
    chk("t2_hit_x", last_hx, 40);
    chk("t2_hit_y", last_hy, 20);
    chk("t2_hit_count", int'(hit_count), 1);
    tick(3);

    // 3: every window hits
    mode = 2; e0 = en_cnt; h0 = hv_cnt; s0 = sd_cnt;
    pulse_start();
    wait_sd(s0 + 1, 10000, "t3_scan_done_seen");
    chk("t3_hit_count", int'(hit_count), 952);
    tick(2);
    chk("t3_hits", hv_cnt - h0, 952);
    chk("t3_last_hit_x", last_hx, 132);
    chk("t3_last_hit_y", last_hy, 108);
    chk("t3_hit_count_held", int'(hit_count), 952);

    // 4: abort in WAIT of window 10, then rescan
    mode = 0; e0 = en_cnt; s0 = sd_cnt;
    pulse_start();
    wait_en(e0 + 11, 200, "t4_reach_win10");
    tick(1);
    do_abort();
    chk("t4_busy_after_abort", int'(busy), 0);
    tick(20);
    chk("t4_no_scan_done", sd_cnt - s0, 0);
    chk("t4_no_more_en", en_cnt - e0, 11);
    e0 = en_cnt;
    pulse_start();
    wait_en(e0 + 1, 10, "t4_restart_en");
    chk("t4_restart_a3", int'(ifc.address_3), 0);
    chk("t4_restart_a0", int'(ifc.address_0), 1288);
    wait_sd(s0 + 1, 10000, "t4_rescan_done");
    chk("t4_rescan_windows", en_cnt - e0, 952);
    tick(3);

    // 5: start during scan and done in IDLE are ignored
    mode = 2; e0 = en_cnt; h0 = hv_cnt; s0 = sd_cnt;
    pulse_start();
    wait_en(e0 + 5, 100, "t5_mid_scan");
    pulse_start();
    wait_sd(s0 + 1, 10000, "t5_scan_done_seen");
    chk("t5_windows", en_cnt - e0, 952);
    chk("t5_hit_count", int'(hit_count), 952);
    tick(3);
    inj_done = 1'b1; inj_flag = 1'b1;
    tick(1);
    inj_done = 1'b0; inj_flag = 1'b0;
    tick(3);
    chk("t5_idle_done_count", int'(hit_count), 952);
    chk("t5_idle_done_hits", hv_cnt - h0, 952);
    chk("t5_idle_busy", int'(busy), 0);

    // 6: classifier never answers
    model_on = 1'b0; mode = 0; e0 = en_cnt;
    pulse_start();
    wait_en(e0 + 1, 10, "t6_first_en");
`ifdef SCAN_TIMEOUT_EN
    tick(63);
    chk("t6_tmo_not_yet", int'(timeout_err), 0);
    tick(1);
    chk("t6_tmo_set", int'(timeout_err), 1);
    wait_en(e0 + 2, 10, "t6_next_window");
    chk("t6_next_a3", int'(ifc.address_3), 4);
    chk("t6_hit_count", int'(hit_count), 0);
    do_abort();
    chk("t6_sticky", int'(timeout_err), 1);
    pulse_start();
    chk("t6_cleared_by_start", int'(timeout_err), 0);
    do_abort();
`else
    tick(200);
    chk("t6_busy_hold", int'(busy), 1);
    chk("t6_no_tmo", int'(timeout_err), 0);
    chk("t6_single_en", en_cnt - e0, 1);
    do_abort();
    chk("t6_abort_idle", int'(busy), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
